md_seq_divider: RTL and testbench

Multi-cycle RV32M divide/remainder unit that answers the execute stage's M-extension request interface (`md_type`, `md_operation`, `md_alu_stall`, `md_alu_done`, `md_result`). It sits inside the EX stage beside the multiplier. While a divide is in progress it holds the pipeline through `md_alu_stall`, then presents the quotient or remainder with a one-cycle `md_alu_done` pulse. The algorithm is radix-2 restoring division, one quotient bit per clock, with early completion for divide-by-zero and signed overflow.

---
 rtl/md_seq_divider_pkg.sv | 37 +++
 rtl/md_seq_divider.sv | 175 +++++++++++++++++
 tb/tb_md_seq_divider.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_seq_divider_pkg.sv
// Shared M-extension definitions: funct3 encodings, divider state type, XLEN.
package md_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 encodings; the multiplier decodes the 0xx half.
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // funct3[2] separates divide/remainder from multiply.
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // DIV and REM are signed; DIVU and REMU have funct3[0] set.
    function automatic logic md_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder.
    function automatic logic md_is_rem(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Holds the pipeline
// via md_alu_stall while iterating, then pulses md_alu_done with the result.
// Divide-by-zero and signed overflow finish after a single stall cycle.
module md_seq_divider
    import md_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_type,
    input  logic [2:0]       md_operation,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    output logic [WIDTH-1:0] md_result,
    output logic             md_alu_stall,
    output logic             md_alu_done
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifts out of the top, quotient bits enter at bit 0
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dvsr_q, dvsr_d;   // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             req;
    logic             op_signed;
    logic             op_rem;
    logic             in1_neg;
    logic             in2_neg;
    logic             div_zero;
    logic             sgn_ovf;
    logic [WIDTH-1:0] in1_mag;
    logic [WIDTH-1:0] in2_mag;
    logic [WIDTH-1:0] special_res;

    // Request decode, operand magnitudes and early-completion results.
    always_comb begin
        req       = md_type & md_is_div(md_operation);
        op_signed = md_is_signed(md_operation);
        op_rem    = md_is_rem(md_operation);
        in1_neg   = op_signed & alu_in1[WIDTH-1];
        in2_neg   = op_signed & alu_in2[WIDTH-1];
        in1_mag   = in1_neg ? -alu_in1 : alu_in1;
        in2_mag   = in2_neg ? -alu_in2 : alu_in2;
        div_zero  = (alu_in2 == '0);
        sgn_ovf   = op_signed & (alu_in1 == MOST_NEG) & (alu_in2 == '1);
        if (div_zero) begin
            special_res = op_rem ? alu_in1 : '1;
        end else begin
            special_res = op_rem ? '0 : alu_in1;
        end
    end

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] final_res;

    // One restoring step plus sign fix-up of the would-be final result.
    always_comb begin
        shifted   = {rem_q, quo_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvsr_q};
        borrow    = trial[WIDTH];
        // On borrow the shifted remainder is below the divisor, so its top bit is zero.
        rem_step  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], ~borrow};
        quo_fix   = neg_quo_q ? -quo_step : quo_step;
        rem_fix   = neg_rem_q ? -rem_step : rem_step;
        final_res = is_rem_q ? rem_fix : quo_fix;
    end

    // Next-state logic, datapath updates and the combinational stall.
    always_comb begin
        state_d      = state_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvsr_d       = dvsr_q;
        cnt_d        = cnt_q;
        is_rem_d     = is_rem_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        result_d     = result_q;
        done_d       = 1'b0;
        md_alu_stall = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                if (req) begin
                    md_alu_stall = 1'b1;
                    quo_d        = in1_mag;
                    dvsr_d       = in2_mag;
                    rem_d        = '0;
                    cnt_d        = CNT_INIT;
                    is_rem_d     = op_rem;
                    neg_quo_d    = op_signed & (alu_in1[WIDTH-1] ^ alu_in2[WIDTH-1]);
                    neg_rem_d    = op_signed & alu_in1[WIDTH-1];
                    if (div_zero || sgn_ovf) begin
                        result_d = special_res;
                        done_d   = 1'b1;
                        state_d  = DIV_DONE;
                    end else begin
                        state_d  = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (!req) begin
                    // Flushed: release the pipeline now, drop the work silently.
                    state_d = DIV_IDLE;
                end else begin
                    md_alu_stall = 1'b1;
                    quo_d        = quo_step;
                    rem_d        = rem_step;
                    cnt_d        = cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        result_d = final_res;
                        done_d   = 1'b1;
                        state_d  = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign md_result   = result_q;
    assign md_alu_done = done_q;

endmodule

// File: tb/tb_md_seq_divider.sv
// Bench for md_seq_divider: directed divides with literal expectations plus a
// cycle-level latency/result model checked on every falling edge.
module tb_md_seq_divider;
    import md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         md_type;
    logic [2:0]   md_operation;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [W-1:0] md_result;
    logic         md_alu_stall;
    logic         md_alu_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: whether a divide is counting down, cycles left, and results.
    bit           m_active;
    bit           m_done;
    int           m_left;
    logic [W-1:0] m_pend;
    logic [W-1:0] m_held;

    always #5 clk = ~clk;

    md_seq_divider #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .md_type      (md_type),
        .md_operation (md_operation),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .md_result    (md_result),
        .md_alu_stall (md_alu_stall),
        .md_alu_done  (md_alu_done)
    );

    function automatic bit is_special(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M divide semantics from plain arithmetic.
    function automatic logic [W-1:0] ref_div(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        bit sgn;
        bit rem;
        sgn = !op[0];
        rem = op[1];
        sa  = a;
        sb  = b;
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
        if (sgn) return rem ? (sa % sb) : (sa / sb);
        return rem ? (a % b) : (a / b);
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] want, input int want_stalls);
        int stalls;
        bit seen;
        stalls = 0;
        seen   = 0;
        @(posedge clk);
        #1;
        md_type      = 1'b1;
        md_operation = op;
        alu_in1      = a;
        alu_in2      = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (md_alu_done) begin
                seen = 1;
                break;
            end
            if (md_alu_stall) stalls++;
            if (i == 2) begin
                alu_in1 = $urandom;
                alu_in2 = $urandom;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("lit_result", md_result, want);
        check("lit_stalls", 32'(stalls), 32'(want_stalls));
        @(posedge clk);
        #1;
        md_type = 1'b0;
    endtask

    initial begin
        int n_stall;
        int n_done;
        int first;
        int second;

        reset        = 1'b1;
        md_type      = 1'b0;
        md_operation = MD_MUL;
        alu_in1      = '0;
        alu_in2      = '0;

        fork
            // Model: latency and result bookkeeping from sampled requests.
            forever begin
                @(posedge clk or posedge reset);
                if (reset) begin
                    m_active = 0;
                    m_done   = 0;
                    m_left   = 0;
                    m_pend   = '0;
                    m_held   = '0;
                end else begin
                    cyc++;
                    if (m_done) begin
                        m_done = 0;
                        m_held = m_pend;
                    end else if (!m_active) begin
                        if (md_type && md_operation[2]) begin
                            m_pend = ref_div(md_operation, alu_in1, alu_in2);
                            if (is_special(md_operation, alu_in1, alu_in2)) begin
                                m_done = 1;
                            end else begin
                                m_active = 1;
                                m_left   = W;
                            end
                        end
                    end else if (!(md_type && md_operation[2])) begin
                        m_active = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_active = 0;
                            m_done   = 1;
                        end
                    end
                end
            end
            // Compare: every falling edge against the model.
            forever begin
                @(negedge clk);
                check("stall", 32'(md_alu_stall), 32'(md_type && md_operation[2] && !m_done));
                check("done", 32'(md_alu_done), 32'(m_done));
                check("result", md_result, m_done ? m_pend : m_held);
            end
            begin
                #1000000;
                $display("FAIL watchdog at t=%0t: got=running want=finished", $time);
                $fatal(1, "timeout");
            end
        join_none

        #1;
        check("rst_result", md_result, 32'h0);
        check("rst_done", 32'(md_alu_done), 32'h0);
        check("rst_stall", 32'(md_alu_stall), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(MD_DIVU, 32'd100,        32'd7,          32'd14,         33);
        run_op(MD_REMU, 32'd100,        32'd7,          32'd2,          33);
        run_op(MD_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
        run_op(MD_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
        run_op(MD_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33);
        run_op(MD_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33);
        run_op(MD_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33);
        run_op(MD_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        run_op(MD_REMU, 32'd5,          32'd0,          32'd5,          1);
        run_op(MD_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1);
        run_op(MD_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        run_op(MD_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1);

        // Multiply funct3 values must be ignored.
        n_stall = 0;
        n_done  = 0;
        @(posedge clk);
        #1;
        md_type      = 1'b1;
        md_operation = MD_MUL;
        alu_in1      = 32'd100;
        alu_in2      = 32'd7;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) md_operation = MD_MULHU;
            if (md_alu_stall) n_stall++;
            if (md_alu_done) n_done++;
        end
        check("mul_stalls", 32'(n_stall), 32'd0);
        check("mul_dones", 32'(n_done), 32'd0);
        md_type = 1'b0;

        // Back-to-back identical divides with the request held across done.
        first  = -1;
        second = -1;
        @(posedge clk);
        #1;
        md_type      = 1'b1;
        md_operation = MD_DIVU;
        alu_in1      = 32'd100;
        alu_in2      = 32'd7;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (md_alu_done) begin
                check("b2b_result", md_result, 32'd14);
                if (first < 0) begin
                    first = cyc;
                end else begin
                    second = cyc;
                    break;
                end
            end
        end
        check("b2b_gap", 32'(second - first), 32'd34);
        @(posedge clk);
        #1;
        md_type = 1'b0;

        // Flush mid-divide: stall drops at once, no completion follows.
        @(posedge clk);
        #1;
        md_type      = 1'b1;
        md_operation = MD_DIVU;
        alu_in1      = 32'd1000;
        alu_in2      = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        md_type = 1'b0;
        #1;
        check("abort_stall", 32'(md_alu_stall), 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_alu_done) n_done++;
        end
        check("abort_dones", 32'(n_done), 32'd0);

        // Asynchronous reset during BUSY cycle 10.
        @(posedge clk);
        #1;
        md_type      = 1'b1;
        md_operation = MD_DIVU;
        alu_in1      = 32'd100;
        alu_in2      = 32'd7;
        repeat (10) @(posedge clk);
        #3;
        reset   = 1'b1;
        md_type = 1'b0;
        #1;
        check("arst_stall", 32'(md_alu_stall), 32'd0);
        check("arst_done", 32'(md_alu_done), 32'd0);
        check("arst_result", md_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(MD_DIVU, 32'd9, 32'd3, 32'd3, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
